// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls and ROM word in, ROM address and IF/ID register contents out.
// The fetch stage uses the master modport; the decode/ROM side uses slave.
interface instruction_fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Stall;
    logic                  BranchTaken;
    logic [DATA_WIDTH-1:0] BranchTarget;
    logic                  Jump;
    logic [DATA_WIDTH-1:0] JumpTarget;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [DATA_WIDTH-1:0] ProgramAddress;
    logic [DATA_WIDTH-1:0] IFID_Instruction;
    logic [DATA_WIDTH-1:0] IFID_PCPlus4;
    logic                  IFID_Valid;
    logic [DATA_WIDTH-1:0] FetchCount;
    logic                  Misaligned;

    modport master (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
        output ProgramAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount, Misaligned
    );

    modport slave (
        output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
        input  ProgramAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount, Misaligned
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: program counter, IF/ID pipeline register and retired-fetch counter.
// Optional macro FETCH_ALIGN_CHECK_EN forces redirect targets word-aligned and raises a sticky Misaligned flag.
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_stage_if.master bus
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        FS_RUN      = 2'd0,
        FS_HOLD     = 2'd1,
        FS_REDIRECT = 2'd2
    } fetch_mode_e;

`ifdef FETCH_ALIGN_CHECK_EN
    function automatic logic [DATA_WIDTH-1:0] align_word(input logic [DATA_WIDTH-1:0] addr);
        return {addr[DATA_WIDTH-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [DATA_WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction
`endif

    logic [DATA_WIDTH-1:0] pc_q,          pc_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q,  ifid_instr_d;
    logic [DATA_WIDTH-1:0] ifid_pcp4_q,   ifid_pcp4_d;
    logic                  ifid_valid_q,  ifid_valid_d;
    logic [DATA_WIDTH-1:0] fetch_cnt_q,   fetch_cnt_d;
    logic                  misaligned_q,  misaligned_d;

    fetch_mode_e           mode_s;
    logic [DATA_WIDTH-1:0] pc_plus4_s;
    logic [DATA_WIDTH-1:0] raw_target_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic                  target_mis_s;

    assign pc_plus4_s   = pc_q + PC_STEP;
    assign raw_target_s = bus.Jump ? bus.JumpTarget : bus.BranchTarget;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_s     = align_word(raw_target_s);
    assign target_mis_s = is_misaligned(raw_target_s);
`else
    assign target_s     = raw_target_s;
    assign target_mis_s = 1'b0;
`endif

    // Per-cycle action: redirect outranks stall, stall outranks sequential fetch.
    always_comb begin
        mode_s = FS_RUN;
        if (bus.Jump || bus.BranchTaken) begin
            mode_s = FS_REDIRECT;
        end else if (bus.Stall) begin
            mode_s = FS_HOLD;
        end else begin
            mode_s = FS_RUN;
        end
    end

    // Next-state for PC, IF/ID and counter according to the selected action.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pcp4_d  = ifid_pcp4_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        misaligned_d = misaligned_q;
        case (mode_s)
            FS_REDIRECT: begin
                // The word fetched this cycle is on the wrong path, so a bubble replaces it.
                pc_d         = target_s;
                ifid_instr_d = '0;
                ifid_pcp4_d  = '0;
                ifid_valid_d = 1'b0;
                misaligned_d = misaligned_q | target_mis_s;
            end
            FS_HOLD: begin
                pc_d         = pc_q;
                ifid_instr_d = ifid_instr_q;
                ifid_pcp4_d  = ifid_pcp4_q;
                ifid_valid_d = ifid_valid_q;
                fetch_cnt_d  = fetch_cnt_q;
            end
            FS_RUN: begin
                pc_d         = pc_plus4_s;
                ifid_instr_d = bus.Instruction;
                ifid_pcp4_d  = pc_plus4_s;
                ifid_valid_d = 1'b1;
                fetch_cnt_d  = fetch_cnt_q + DATA_WIDTH'(1);
            end
            default: begin
                pc_d         = pc_q;
                ifid_instr_d = ifid_instr_q;
                ifid_pcp4_d  = ifid_pcp4_q;
                ifid_valid_d = ifid_valid_q;
                fetch_cnt_d  = fetch_cnt_q;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pcp4_q  <= '0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pcp4_q  <= ifid_pcp4_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.ProgramAddress   = pc_q;
    assign bus.IFID_Instruction = ifid_instr_q;
    assign bus.IFID_PCPlus4     = ifid_pcp4_q;
    assign bus.IFID_Valid       = ifid_valid_q;
    assign bus.FetchCount       = fetch_cnt_q;
    assign bus.Misaligned       = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a fetch model queues expected post-edge state,
// a monitor compares it after every clock edge. A second instance exercises PC wrap from RESET_PC.
module tb_instruction_fetch_stage;

    localparam logic [31:0] BASE_PC = 32'h0040_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk;
    logic reset;
    logic reset2;

    instruction_fetch_stage_if #(.DATA_WIDTH(32)) bus ();
    instruction_fetch_stage_if #(.DATA_WIDTH(32)) bus2 ();

    instruction_fetch_stage #(.DATA_WIDTH(32), .RESET_PC(BASE_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instruction_fetch_stage #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign bus.Instruction  = rom_word(bus.ProgramAddress);
    assign bus2.Instruction = rom_word(bus2.ProgramAddress);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference fetch state: what IF/ID should hold after the next edge.
    logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
    logic        m_valid, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                               input bit jp, input logic [31:0] jt);
        logic [31:0] tgt;
        exp_t e;
        @(negedge clk);
        reset            = rst;
        bus.Stall        = st;
        bus.BranchTaken  = br;
        bus.BranchTarget = bt;
        bus.Jump         = jp;
        bus.JumpTarget   = jt;
        if (rst) begin
            m_pc = BASE_PC; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
        end else if (jp || br) begin
            tgt = jp ? jt : bt;
`ifdef FETCH_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            m_pc = tgt; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = rom_word(m_pc);
            m_pcp4  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pcp4;
        end
        e.pc = m_pc; e.instr = m_instr; e.pcp4 = m_pcp4; e.valid = m_valid; e.cnt = m_cnt; e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: after each edge compare DUT state with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ProgramAddress", bus.ProgramAddress, e.pc);
                chk("IFID_Instruction", bus.IFID_Instruction, e.instr);
                chk("IFID_PCPlus4", bus.IFID_PCPlus4, e.pcp4);
                chk("IFID_Valid", {31'h0, bus.IFID_Valid}, {31'h0, e.valid});
                chk("FetchCount", bus.FetchCount, e.cnt);
                chk("Misaligned", {31'h0, bus.Misaligned}, {31'h0, e.mis});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bt, jt;
        int r;
        reset = 1'b1; reset2 = 1'b1;
        bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = 32'h0;
        bus.Jump = 1'b0; bus.JumpTarget = 32'h0;
        bus2.Stall = 1'b0; bus2.BranchTaken = 1'b0; bus2.BranchTarget = 32'h0;
        bus2.Jump = 1'b0; bus2.JumpTarget = 32'h0;

        // Directed: reset, free run, stall, branch, combined jump/branch/stall.
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        seq(2);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        seq(2);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b0, 32'h0);
        seq(2);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0040);
        seq(3);
        // Misaligned redirect, then aligned redirect and stall: flag must not clear.
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0022);
        seq(1);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        seq(1);
        // Wrap of PC+4 past the top of the address space.
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        seq(3);
        // Mid-run reset then random traffic.
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0300);
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 99);
            bt = BASE_PC + {22'h0, $urandom_range(0, 255), 2'b00};
            jt = BASE_PC + {22'h0, $urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 9) == 0) bt[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) jt[1:0] = 2'($urandom_range(0, 3));
            drive_cycle(r < 2, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, bt,
                        $urandom_range(0, 15) == 0, jt);
        end
        seq(2);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        // RESET_PC at the top of memory: first fetch wraps PC and PC+4 to zero.
        chk("wrap_reset_pc", bus2.ProgramAddress, WRAP_PC);
        chk("wrap_reset_valid", {31'h0, bus2.IFID_Valid}, 32'h0);
        reset2 = 1'b0;
        @(negedge clk);
        chk("wrap_next_pc", bus2.ProgramAddress, 32'h0);
        chk("wrap_pcplus4", bus2.IFID_PCPlus4, 32'h0);
        chk("wrap_instr", bus2.IFID_Instruction, rom_word(WRAP_PC));
        chk("wrap_valid", {31'h0, bus2.IFID_Valid}, 32'h1);
        chk("wrap_count", bus2.FetchCount, 32'h1);
        @(negedge clk);
        chk("wrap_second_pc", bus2.ProgramAddress, 32'h4);
        chk("wrap_second_pcplus4", bus2.IFID_PCPlus4, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
